// File: rtl/instr_decode_stage_pkg.sv
// Shared types for the MIPS-lite decode stage: opcodes, the ID/EX bundle and constants.
package Types;

  localparam int ADD_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [31:0] INVALID_INSTR = 32'hDEADBEEF;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11
  } opcode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic                  valid;
    logic [5:0]            opcode;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic [31:0]           imm;
    logic [4:0]            dest;
    logic                  writes_reg;
    logic [ADD_WIDTH-1:0]  pc_added4;
  } IdEx_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_slot_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch/decode/write-back handshake bundle seen by the decode stage.
interface instr_decode_stage_if #(
  parameter int ADD_WIDTH  = Types::ADD_WIDTH,
  parameter int DATA_WIDTH = Types::DATA_WIDTH
);

  logic [31:0]           instruction;
  logic [ADD_WIDTH-1:0]  pc_added4;
  logic                  is_taken;
  logic                  wb_en;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  hazard_detected;
  logic                  halt_detected;
  Types::IdEx_t          id_ex;

  modport slave (
    input  instruction, pc_added4, is_taken, wb_en, wb_rd, wb_data,
    output hazard_detected, halt_detected, id_ex
  );

  modport master (
    output instruction, pc_added4, is_taken, wb_en, wb_rd, wb_data,
    input  hazard_detected, halt_detected, id_ex
  );

endinterface

// File: rtl/instr_decode_stage_regfile.sv
// Register file: two combinational read ports with write-through, one write port, R0 reads 0.
module regfile #(
  parameter int NUM_REGS   = Types::NUM_REGS,
  parameter int DATA_WIDTH = Types::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [4:0]            rd_addr_a_i,
  output logic [DATA_WIDTH-1:0] rd_data_a_o,
  input  logic [4:0]            rd_addr_b_i,
  output logic [DATA_WIDTH-1:0] rd_data_b_o,
  input  logic                  wr_en_i,
  input  logic [4:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A same-cycle write wins so a stalled consumer sees the result as the stall ends.
  always_comb begin
    rd_data_a_o = '0;
    if (rd_addr_a_i != '0) begin
      if (wr_en_i && (wr_addr_i == rd_addr_a_i)) rd_data_a_o = wr_data_i;
      else                                       rd_data_a_o = regs_q[rd_addr_a_i];
    end
  end

  always_comb begin
    rd_data_b_o = '0;
    if (rd_addr_b_i != '0) begin
      if (wr_en_i && (wr_addr_i == rd_addr_b_i)) rd_data_b_o = wr_data_i;
      else                                       rd_data_b_o = regs_q[rd_addr_b_i];
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// MIPS-lite decode stage: IF/ID register, register file, two-slot RAW scoreboard, registered ID/EX.
// Optional DECODE_STATS_EN adds saturating issue/stall/flush counters.
module instr_decode_stage #(
  parameter int ADD_WIDTH  = Types::ADD_WIDTH,
  parameter int DATA_WIDTH = Types::DATA_WIDTH,
  parameter int NUM_REGS   = Types::NUM_REGS
) (
  input  logic                 clock,
  input  logic                 rst_n,
  instr_decode_stage_if.slave  bus
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stalls,
  output logic [31:0]          stat_flushes
`endif
);

  // state     | meaning
  // ST_RUN    | decoding and issuing normally
  // ST_HALTED | HALT has issued; IF/ID is flushed every cycle until reset

  Types::dec_state_e     state_q, state_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [31:0]           ifid_instr_q, ifid_instr_d;
  logic [ADD_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
  Types::sb_slot_t       slot0_q, slot0_d;
  Types::sb_slot_t       slot1_q, slot1_d;
  Types::IdEx_t          id_ex_q, id_ex_d;

  logic [5:0]            op;
  logic [4:0]            rs, rt, rd;
  logic [15:0]           imm16;
  logic [DATA_WIDTH-1:0] rs_val, rt_val;

  logic                  known_op, reads_rs, reads_rt, wr_reg;
  logic [4:0]            dec_dest;
  logic                  rs_hit, rt_hit, raw, halted, hazard, issue;

  assign op    = ifid_instr_q[31:26];
  assign rs    = ifid_instr_q[25:21];
  assign rt    = ifid_instr_q[20:16];
  assign rd    = ifid_instr_q[15:11];
  assign imm16 = ifid_instr_q[15:0];

  regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clock       (clock),
    .rst_n       (rst_n),
    .rd_addr_a_i (rs),
    .rd_data_a_o (rs_val),
    .rd_addr_b_i (rt),
    .rd_data_b_o (rt_val),
    .wr_en_i     (bus.wb_en),
    .wr_addr_i   (bus.wb_rd),
    .wr_data_i   (bus.wb_data)
  );

  // ALU ops pair up: even opcode is register form (dest rd), odd is immediate (dest rt).
  always_comb begin
    known_op = 1'b0;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    wr_reg   = 1'b0;
    dec_dest = '0;
    if (op <= 6'h0B) begin
      known_op = 1'b1;
      reads_rs = 1'b1;
      wr_reg   = 1'b1;
      if (op[0]) begin
        dec_dest = rt;
      end else begin
        reads_rt = 1'b1;
        dec_dest = rd;
      end
    end else begin
      case (op)
        Types::OP_LDW: begin
          known_op = 1'b1;
          reads_rs = 1'b1;
          wr_reg   = 1'b1;
          dec_dest = rt;
        end
        Types::OP_STW, Types::OP_BEQ: begin
          known_op = 1'b1;
          reads_rs = 1'b1;
          reads_rt = 1'b1;
        end
        Types::OP_BZ, Types::OP_JR: begin
          known_op = 1'b1;
          reads_rs = 1'b1;
        end
        Types::OP_HALT: known_op = 1'b1;
        default: ;
      endcase
    end
  end

  function automatic logic slot_hit(input Types::sb_slot_t s, input logic [4:0] r);
    return s.valid && (s.dest == r);
  endfunction

  assign rs_hit = reads_rs && (rs != '0) && (slot_hit(slot0_q, rs) || slot_hit(slot1_q, rs));
  assign rt_hit = reads_rt && (rt != '0) && (slot_hit(slot0_q, rt) || slot_hit(slot1_q, rt));
  assign raw    = ifid_valid_q && (rs_hit || rt_hit);
  assign halted = (state_q == Types::ST_HALTED);
  assign hazard = raw && !bus.is_taken && !halted;
  assign issue  = ifid_valid_q && known_op && !raw && !bus.is_taken && !halted;

  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    id_ex_d      = '0;
    slot0_d      = '0;
    slot1_d      = slot0_q;

    // Flush beats stall: a taken branch or halt empties IF/ID even mid-stall.
    if (bus.is_taken || halted) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
    end else if (!raw) begin
      ifid_valid_d = (bus.instruction != Types::INVALID_INSTR);
      ifid_instr_d = bus.instruction;
      ifid_pc_d    = bus.pc_added4;
    end

    if (issue) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.opcode     = op;
      id_ex_d.rs_val     = rs_val;
      id_ex_d.rt_val     = rt_val;
      id_ex_d.imm        = Types::sign_ext16(imm16);
      id_ex_d.dest       = dec_dest;
      id_ex_d.writes_reg = wr_reg;
      id_ex_d.pc_added4  = ifid_pc_q;
      slot0_d.valid      = wr_reg;
      slot0_d.dest       = dec_dest;
    end

    case (state_q)
      Types::ST_RUN:    if (issue && (op == Types::OP_HALT)) state_d = Types::ST_HALTED;
      Types::ST_HALTED: state_d = Types::ST_HALTED;
      default:          state_d = Types::ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= Types::ST_RUN;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      id_ex_q      <= '0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      id_ex_q      <= id_ex_d;
    end
  end

  assign bus.hazard_detected = hazard;
  assign bus.halt_detected   = halted;
  assign bus.id_ex           = id_ex_q;

`ifdef DECODE_STATS_EN
  logic [31:0] stat_issued_q, stat_stalls_q, stat_flushes_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q  <= '0;
      stat_stalls_q  <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (issue && (stat_issued_q != '1))         stat_issued_q  <= stat_issued_q + 32'd1;
      if (hazard && (stat_stalls_q != '1))        stat_stalls_q  <= stat_stalls_q + 32'd1;
      if (bus.is_taken && (stat_flushes_q != '1)) stat_flushes_q <= stat_flushes_q + 32'd1;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_stalls  = stat_stalls_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage: reset, issue, RAW stall, flush, HALT.
module tb_instr_decode_stage;

  localparam logic [31:0] INV = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  instr_decode_stage_if dif ();

`ifdef DECODE_STATS_EN
  logic [31:0] stat_issued, stat_stalls, stat_flushes;
`endif

  instr_decode_stage dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (dif)
`ifdef DECODE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_stalls  (stat_stalls),
    .stat_flushes (stat_flushes)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    dif.instruction = ins;
    dif.pc_added4   = pc;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  initial begin
    dif.instruction = INV;
    dif.pc_added4   = '0;
    dif.is_taken    = 1'b0;
    dif.wb_en       = 1'b0;
    dif.wb_rd       = '0;
    dif.wb_data     = '0;

    // Power-on reset
    rst_n = 1'b0;
    tick();
    tick();
    check("por_idex_valid", dif.id_ex.valid, 1'b0);
    check("por_halt", dif.halt_detected, 1'b0);
    check("por_hazard", dif.hazard_detected, 1'b0);
    rst_n = 1'b1;

    // Preload R0..R31 with 0x100+r; the R0 write must be ignored
    for (int r = 0; r < 32; r++) begin
      dif.wb_en   = 1'b1;
      dif.wb_rd   = 5'(r);
      dif.wb_data = 32'h100 + 32'(r);
      tick();
    end
    dif.wb_en = 1'b0;

    // No-hazard stream
    drive(enc_i(6'h01, 5'd0, 5'd1, 16'd5), 32'h4);
    tick();
    drive(enc_i(6'h01, 5'd0, 5'd2, 16'd7), 32'h8);
    #1 check("nh_haz0", dif.hazard_detected, 1'b0);
    tick();
    check("nh_a_valid", dif.id_ex.valid, 1'b1);
    check("nh_a_op", dif.id_ex.opcode, 6'h01);
    check("nh_a_imm", dif.id_ex.imm, 32'd5);
    check("nh_a_dest", dif.id_ex.dest, 5'd1);
    check("nh_a_wr", dif.id_ex.writes_reg, 1'b1);
    check("nh_a_r0", dif.id_ex.rs_val, 32'd0);
    check("nh_a_pc", dif.id_ex.pc_added4, 32'h4);
    drive(enc_r(6'h00, 5'd3, 5'd4, 5'd9), 32'hC);
    #1 check("nh_haz1", dif.hazard_detected, 1'b0);
    tick();
    check("nh_b_valid", dif.id_ex.valid, 1'b1);
    check("nh_b_imm", dif.id_ex.imm, 32'd7);
    check("nh_b_dest", dif.id_ex.dest, 5'd2);
    drive(enc_i(6'h01, 5'd0, 5'd10, 16'hFFFE), 32'h10);
    #1 check("nh_haz2", dif.hazard_detected, 1'b0);
    tick();
    check("nh_c_rs", dif.id_ex.rs_val, 32'h103);
    check("nh_c_rt", dif.id_ex.rt_val, 32'h104);
    check("nh_c_dest", dif.id_ex.dest, 5'd9);
    check("nh_c_imm", dif.id_ex.imm, 32'h4800);
    drive(INV, 32'h14);
    tick();
    check("nh_d_imm", dif.id_ex.imm, 32'hFFFF_FFFE);
    check("nh_d_dest", dif.id_ex.dest, 5'd10);
    tick();
    check("inv_bubble", dif.id_ex.valid, 1'b0);

    // Reset asserted in the middle of a RAW stall
    drive(enc_i(6'h01, 5'd0, 5'd1, 16'd5), 32'h20);
    tick();
    drive(enc_r(6'h00, 5'd1, 5'd1, 5'd3), 32'h24);
    tick();
    #1 check("mr_pre_haz", dif.hazard_detected, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_haz", dif.hazard_detected, 1'b0);
    check("mr_idex_valid", dif.id_ex.valid, 1'b0);
    check("mr_halt", dif.halt_detected, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(INV, 32'h0);

    // All registers read 0 after reset (ADD R0, R(2k+1), R(2k+2))
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) drive(enc_r(6'h00, 5'(2 * k + 1), 5'(2 * k + 2), 5'd0), 32'h0);
      else        drive(INV, 32'h0);
      tick();
      if (k > 0) begin
        check("rst_rd_valid", dif.id_ex.valid, 1'b1);
        check("rst_rd_rs", dif.id_ex.rs_val, 32'd0);
        check("rst_rd_rt", dif.id_ex.rt_val, 32'd0);
      end
    end

    // Fresh reset so the statistics start at zero for the RAW case
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // RAW stall: ADDI R1,R0,5 then ADD R3,R1,R1, write-back 3 edges after issue
    drive(enc_i(6'h01, 5'd0, 5'd1, 16'd5), 32'h40);
    tick();
    drive(enc_r(6'h00, 5'd1, 5'd1, 5'd3), 32'h44);
    #1 check("raw_haz0", dif.hazard_detected, 1'b0);
    tick();
    drive(INV, 32'h48);
    #1 check("raw_haz1", dif.hazard_detected, 1'b1);
    check("raw_prod_imm", dif.id_ex.imm, 32'd5);
    tick();
    #1 check("raw_haz2", dif.hazard_detected, 1'b1);
    check("raw_bub1", dif.id_ex.valid, 1'b0);
    tick();
    dif.wb_en   = 1'b1;
    dif.wb_rd   = 5'd1;
    dif.wb_data = 32'd5;
    #1 check("raw_haz3", dif.hazard_detected, 1'b0);
    check("raw_bub2", dif.id_ex.valid, 1'b0);
    tick();
    dif.wb_en = 1'b0;
    check("raw_iss_valid", dif.id_ex.valid, 1'b1);
    check("raw_iss_op", dif.id_ex.opcode, 6'h00);
    check("raw_iss_dest", dif.id_ex.dest, 5'd3);
    check("raw_iss_rs", dif.id_ex.rs_val, 32'd5);
    check("raw_iss_rt", dif.id_ex.rt_val, 32'd5);
    check("raw_iss_pc", dif.id_ex.pc_added4, 32'h44);
`ifdef DECODE_STATS_EN
    check("stat_issued", stat_issued, 32'd2);
    check("stat_stalls", stat_stalls, 32'd2);
    check("stat_flushes", stat_flushes, 32'd0);
`endif
    tick();
    tick();

    // Taken branch during the first stall cycle
    drive(enc_i(6'h01, 5'd0, 5'd6, 16'd9), 32'h80);
    tick();
    drive(enc_r(6'h00, 5'd6, 5'd6, 5'd7), 32'h84);
    tick();
    #1 check("br_pre_haz", dif.hazard_detected, 1'b1);
    dif.is_taken = 1'b1;
    drive(INV, 32'h88);
    #1 check("br_haz", dif.hazard_detected, 1'b0);
    tick();
    dif.is_taken = 1'b0;
    drive(enc_i(6'h01, 5'd0, 5'd8, 16'd3), 32'h104);
    #1 check("br_bub1", dif.id_ex.valid, 1'b0);
    check("br_haz_after", dif.hazard_detected, 1'b0);
    tick();
    drive(INV, 32'h108);
    check("br_bub2", dif.id_ex.valid, 1'b0);
    tick();
    check("br_tgt_valid", dif.id_ex.valid, 1'b1);
    check("br_tgt_imm", dif.id_ex.imm, 32'd3);
    check("br_tgt_pc", dif.id_ex.pc_added4, 32'h104);

    // HALT followed by ADDI R4,R0,1
    drive({6'h11, 26'd0}, 32'h200);
    tick();
    drive(enc_i(6'h01, 5'd0, 5'd4, 16'd1), 32'h204);
    #1 check("halt_pre", dif.halt_detected, 1'b0);
    tick();
    check("halt_iss_valid", dif.id_ex.valid, 1'b1);
    check("halt_iss_op", dif.id_ex.opcode, 6'h11);
    check("halt_iss_wr", dif.id_ex.writes_reg, 1'b0);
    check("halt_set", dif.halt_detected, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_no_issue", dif.id_ex.valid, 1'b0);
      check("halt_sticky", dif.halt_detected, 1'b1);
      check("halt_no_haz", dif.hazard_detected, 1'b0);
    end

    // Taken branch with HALT in ID: flush wins
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_halt", dif.halt_detected, 1'b0);
    drive({6'h11, 26'd0}, 32'h300);
    tick();
    dif.is_taken = 1'b1;
    drive(INV, 32'h304);
    tick();
    dif.is_taken = 1'b0;
    check("brh_bubble", dif.id_ex.valid, 1'b0);
    check("brh_halt", dif.halt_detected, 1'b0);
    tick();
    check("brh_halt2", dif.halt_detected, 1'b0);
    check("brh_bubble2", dif.id_ex.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
